// File: rtl/rdma_scatter_axil_cfg_master.sv
// rdma_scatter_axil_cfg_master
//   AXI4-Lite master that programs the RDMA-scatter control register file.
//   One accepted command (four scatter vaddrs) produces five sequential
//   register writes: VADDR_1..VADDR_4, then VADDR_VALID = 1. Completion is
//   signalled with a one-cycle done pulse, with err/err_idx reporting the
//   first non-OKAY write response (remaining writes are skipped).
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   cfg_valid / cfg_ready    command handshake (ready only while idle)
//   cfg_vaddr_1..4           scatter virtual addresses (zero-extended)
//   axi_ctrl_*               AXI4-Lite master port (read channels idle)
//   busy                     accept through the done cycle
//   done                     one-cycle completion pulse
//   err, err_idx             error flag / failing write index, held until
//                            the next accepted command
module rdma_scatter_axil_cfg_master #(
  parameter int unsigned                AXIL_ADDR_BITS = 64,
  parameter int unsigned                AXIL_DATA_BITS = 64,
  parameter int unsigned                VADDR_BITS     = 48,
  parameter logic [AXIL_ADDR_BITS-1:0]  BASE_ADDR      = '0,
  parameter int unsigned                REG_STRIDE     = AXIL_DATA_BITS / 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [VADDR_BITS-1:0]         cfg_vaddr_1,
  input  logic [VADDR_BITS-1:0]         cfg_vaddr_2,
  input  logic [VADDR_BITS-1:0]         cfg_vaddr_3,
  input  logic [VADDR_BITS-1:0]         cfg_vaddr_4,

  output logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_awaddr,
  output logic [2:0]                    axi_ctrl_awprot,
  output logic                          axi_ctrl_awvalid,
  input  logic                          axi_ctrl_awready,
  output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
  output logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
  output logic                          axi_ctrl_wvalid,
  input  logic                          axi_ctrl_wready,
  input  logic [1:0]                    axi_ctrl_bresp,
  input  logic                          axi_ctrl_bvalid,
  output logic                          axi_ctrl_bready,
  output logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_araddr,
  output logic [2:0]                    axi_ctrl_arprot,
  output logic                          axi_ctrl_arvalid,
  input  logic                          axi_ctrl_arready,
  input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
  input  logic [1:0]                    axi_ctrl_rresp,
  input  logic                          axi_ctrl_rvalid,
  output logic                          axi_ctrl_rready,

  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_DONE
  } state_t;

  state_t                    state;
  logic [2:0]                idx;
  logic [2:0]                idx_nxt;
  logic                      aw_done;
  logic                      w_done;
  logic                      aw_hs;
  logic                      w_hs;
  logic [AXIL_DATA_BITS-1:0] vaddr_q [4];

  // Read channels are never used by this master.
  logic unused_rd;
  assign unused_rd = ^{axi_ctrl_arready, axi_ctrl_rdata, axi_ctrl_rresp, axi_ctrl_rvalid};

  assign axi_ctrl_awprot  = '0;
  assign axi_ctrl_araddr  = '0;
  assign axi_ctrl_arprot  = '0;
  assign axi_ctrl_arvalid = 1'b0;
  assign axi_ctrl_rready  = 1'b1;

  assign aw_hs   = axi_ctrl_awvalid & axi_ctrl_awready;
  assign w_hs    = axi_ctrl_wvalid & axi_ctrl_wready;
  assign idx_nxt = idx + 3'd1;

  // Register address; the sum wraps in the address width.
  function automatic logic [AXIL_ADDR_BITS-1:0] reg_addr(input logic [2:0] i);
    return BASE_ADDR + (AXIL_ADDR_BITS'(i) * AXIL_ADDR_BITS'(REG_STRIDE));
  endfunction

  // Write payload for write i (> 0); write 4 is the VADDR_VALID strobe.
  function automatic logic [AXIL_DATA_BITS-1:0] reg_data(input logic [2:0] i);
    if (i == 3'd4) return AXIL_DATA_BITS'(1);
    return vaddr_q[i[1:0]];
  endfunction

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state            <= S_IDLE;
      idx              <= '0;
      aw_done          <= 1'b0;
      w_done           <= 1'b0;
      cfg_ready        <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      err_idx          <= '0;
      axi_ctrl_awvalid <= 1'b0;
      axi_ctrl_wvalid  <= 1'b0;
      axi_ctrl_bready  <= 1'b0;
      axi_ctrl_awaddr  <= '0;
      axi_ctrl_wdata   <= '0;
      axi_ctrl_wstrb   <= '0;
      for (int unsigned i = 0; i < 4; i++) vaddr_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            vaddr_q[0]       <= AXIL_DATA_BITS'(cfg_vaddr_1);
            vaddr_q[1]       <= AXIL_DATA_BITS'(cfg_vaddr_2);
            vaddr_q[2]       <= AXIL_DATA_BITS'(cfg_vaddr_3);
            vaddr_q[3]       <= AXIL_DATA_BITS'(cfg_vaddr_4);
            idx              <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            cfg_ready        <= 1'b0;
            busy             <= 1'b1;
            err              <= 1'b0;
            err_idx          <= '0;
            // First write is loaded straight from the command inputs,
            // since vaddr_q only updates on this same edge.
            axi_ctrl_awaddr  <= reg_addr(3'd0);
            axi_ctrl_wdata   <= AXIL_DATA_BITS'(cfg_vaddr_1);
            axi_ctrl_wstrb   <= '1;
            axi_ctrl_awvalid <= 1'b1;
            axi_ctrl_wvalid  <= 1'b1;
            state            <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // AW and W retire independently; each valid drops after its own beat.
          if (aw_hs) begin
            axi_ctrl_awvalid <= 1'b0;
            aw_done          <= 1'b1;
          end
          if (w_hs) begin
            axi_ctrl_wvalid <= 1'b0;
            w_done          <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            axi_ctrl_bready <= 1'b1;
            state           <= S_RESP;
          end
        end

        S_RESP: begin
          if (axi_ctrl_bvalid) begin
            axi_ctrl_bready <= 1'b0;
            if (axi_ctrl_bresp != 2'b00) begin
              err     <= 1'b1;
              err_idx <= idx;
              done    <= 1'b1;
              state   <= S_DONE;
            end else if (idx == 3'd4) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx              <= idx_nxt;
              aw_done          <= 1'b0;
              w_done           <= 1'b0;
              axi_ctrl_awaddr  <= reg_addr(idx_nxt);
              axi_ctrl_wdata   <= reg_data(idx_nxt);
              axi_ctrl_awvalid <= 1'b1;
              axi_ctrl_wvalid  <= 1'b1;
              state            <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rdma_scatter_axil_cfg_master.md
# rdma_scatter_axil_cfg_master

AXI4-Lite master that programs the RDMA-scatter vFPGA control register file from hardware. It accepts one configuration command holding four scatter virtual addresses and issues five sequential AXI4-Lite writes: VADDR_1..VADDR_4, then VADDR_VALID = 1. It reports completion and any error response. It sits between an on-chip command source (e.g. a control FSM or a test harness) and the scatter control register slave.

## Interface
- BASE_ADDR, default 0: byte address of register 0 in the slave map.
- REG_STRIDE, default AXIL_DATA_BITS/8 (8): byte stride between consecutive registers.
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  command accepted when high together with cfg_valid.
- cfg_vaddr_1..cfg_vaddr_4  in  VADDR_BITS each  scatter addresses.
- axi_ctrl  AXI4L.m  AXIL_DATA_BITS data  register-write port to the slave.
- busy  out  1  high from command accept until the cycle after done.
- done  out  1  single-cycle pulse at sequence end.
- err  out  1  valid with done; 1 = a non-OKAY bresp was received.
- err_idx  out  3  valid with done; index (0..4) of the failing write, 0 when err=0.

## Operation
- States: IDLE, ISSUE, RESP, DONE. Write index idx is 0..4.
- IDLE: cfg_ready=1. On cfg_valid&&cfg_ready: latch the four vaddrs, zero-extended to AXIL_DATA_BITS. Set idx=0 and go to ISSUE.
- ISSUE: awvalid=wvalid=1. awaddr=BASE_ADDR+idx*REG_STRIDE, computed in the awaddr width with the carry discarded. wdata=vaddr[idx], or 1 for idx=4. wstrb=all ones. awprot=0.
  - The AW and W channels complete independently. Each valid deasserts on the cycle after its own handshake. Address and data stay stable while valid is high.
  - Valid never depends on ready.
  - When both handshakes are done (same or different cycles), go to RESP.
- RESP: bready=1. On bvalid:
  - bresp!=OKAY: set err=1, err_idx=idx, go to DONE. Remaining writes are skipped; VALID is not written.
  - bresp==OKAY and idx==4: go to DONE.
  - Otherwise: idx++, go to ISSUE.
- DONE: done=1 for one cycle with err/err_idx, then go to IDLE. err/err_idx hold until the next accept, which clears them.
- Read channels unused: arvalid=0, araddr=0, rready=1.
- Commands are not queued. cfg_ready=0 outside IDLE.

## Timing
- Reset values:
  - State IDLE, cfg_ready=1.
  - busy=0, done=0, err=0, err_idx=0.
  - awvalid=0, wvalid=0, bready=0, arvalid=0.
  - awaddr=0, wdata=0, wstrb=0.
- Reset mid-sequence: abandon immediately and return to reset values. No completion is reported.
- Accept cycle T. awvalid/wvalid rise at T+1.
- Per write, zero-wait slave: AW/W handshake 1 cycle, then B handshake 1 cycle, i.e. 2 cycles per write.
  - Full sequence: done at T+11 (5 writes × 2 cycles after T+1).
  - A slave that registers awready/wready one cycle late and returns bvalid one cycle later takes 3 cycles per write; done at T+16.
- bvalid arriving while in ISSUE, before both handshakes: not legal AXI; ignored until RESP.
- done and cfg_ready are never high in the same cycle. The next accept is possible on the cycle after done.

## Test plan
- Reset, then idle 10 cycles -> all outputs at reset values, no AXI valids.
- Command vaddrs 0x1000, 0x2000, 0x3000, 0x4000; BASE_ADDR=0; zero-wait responder -> five writes, in order:
  - 0x00/0x1000, 0x08/0x2000, 0x10/0x3000, 0x18/0x4000, 0x20/0x1.
  - wstrb=0xFF.
  - done at T+11, err=0.
- Responder delays wready 3 cycles after awready on write 2 -> awvalid drops after its own handshake and wvalid holds with stable data. Result: single AW beat per write, same write contents as above.
- Responder returns SLVERR on write idx 2 -> only 3 writes are issued (VALID never written). done with err=1, err_idx=2. The next command clears err.
- aresetn low for one cycle during RESP of write 3 -> all outputs reset, no done. A new command afterwards completes a full 5-write sequence.
- cfg_valid held high continuously with a fixed payload -> back-to-back sequences, one accept per sequence, with cfg_ready low from accept through done.
